// File: rtl/lcd_fifo_param_if.sv
// Handshake and status bundle of the parameterised LCD FIFO.
// The master side drives requests and thresholds; the slave side is the FIFO.
interface lcd_fifo_param_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic          push;
    logic [DW-1:0] wdata;
    logic          pull;
    logic [DW-1:0] rdata;
    logic          flush;
    logic [AW:0]   afull_th;
    logic [AW:0]   aempty_th;
    logic          err_clr;
    logic          full;
    logic          fifoempty;
    logic          afull;
    logic          aempty;
    logic [AW:0]   cnt;
    logic          ovf;
    logic          udf;

    modport master (
        output push, wdata, pull, flush, afull_th, aempty_th, err_clr,
        input  rdata, full, fifoempty, afull, aempty, cnt, ovf, udf
    );

    modport slave (
        input  push, wdata, pull, flush, afull_th, aempty_th, err_clr,
        output rdata, full, fifoempty, afull, aempty, cnt, ovf, udf
    );
endinterface

// File: rtl/lcd_fifo_param.sv
// First-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module lcd_fifo_param #(
    parameter int DW    = 32,
    parameter int DEPTH = 32
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    lcd_fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] rpt_r, wpt_r, rpt_s, wpt_s;
    logic [AW:0]   cnt_r, cnt_s;
    logic          ovf_r, udf_r, ovf_s, udf_s;
    logic          pop_ok_s, push_ok_s, ovf_set_s, udf_set_s;

    // Next-state: acceptance decisions, pointer/count update and sticky flags.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        ovf_set_s = 1'b0;
        udf_set_s = 1'b0;
        rpt_s     = rpt_r;
        wpt_s     = wpt_r;
        cnt_s     = cnt_r;

        if (bus.flush) begin
            // Flush drops any concurrent request; it is not treated as an error.
            rpt_s = PTR_ZERO;
            wpt_s = PTR_ZERO;
            cnt_s = CNT_ZERO;
        end else begin
            pop_ok_s  = bus.pull && (cnt_r != CNT_ZERO);
            push_ok_s = bus.push && ((cnt_r != DEPTH_C) || pop_ok_s);
            ovf_set_s = bus.push && !push_ok_s;
            udf_set_s = bus.pull && (cnt_r == CNT_ZERO);

            if (pop_ok_s) begin
                rpt_s = rpt_r + PTR_ONE;
            end else begin
                rpt_s = rpt_r;
            end

            if (push_ok_s) begin
                wpt_s = wpt_r + PTR_ONE;
            end else begin
                wpt_s = wpt_r;
            end

            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_s = cnt_r + CNT_ONE;
                2'b01:   cnt_s = cnt_r - CNT_ONE;
                default: cnt_s = cnt_r;
            endcase
        end

        // A new error outranks a coincident clear.
        if (bus.err_clr) begin
            ovf_s = ovf_set_s;
            udf_s = udf_set_s;
        end else begin
            ovf_s = ovf_r | ovf_set_s;
            udf_s = udf_r | udf_set_s;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rpt_r <= PTR_ZERO;
            wpt_r <= PTR_ZERO;
            cnt_r <= CNT_ZERO;
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            rpt_r <= rpt_s;
            wpt_r <= wpt_s;
            cnt_r <= cnt_s;
            ovf_r <= ovf_s;
            udf_r <= udf_s;
        end
    end

    // Storage array write port; contents are deliberately left unreset.
    always_ff @(posedge HCLK) begin
        if (push_ok_s) begin
            mem_r[wpt_r] <= bus.wdata;
        end
    end

    assign bus.rdata     = mem_r[rpt_r];
    assign bus.cnt       = cnt_r;
    assign bus.full      = (cnt_r == DEPTH_C);
    assign bus.fifoempty = (cnt_r == CNT_ZERO);
    assign bus.afull     = (cnt_r >= bus.afull_th);
    assign bus.aempty    = (cnt_r <= bus.aempty_th);
    assign bus.ovf       = ovf_r;
    assign bus.udf       = udf_r;
endmodule

// File: tb/tb_lcd_fifo_param.sv
// Scoreboard bench for lcd_fifo_param: a queue-based reference model predicts
// the post-edge state, a separate monitor compares it after each rising edge.
module tb_lcd_fifo_param;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    lcd_fifo_param_if #(.DW(DW), .DEPTH(DEPTH)) bus();

    lcd_fifo_param #(.DW(DW), .DEPTH(DEPTH)) dut (
        .HCLK    (clk),
        .HRESETn (rstn),
        .bus     (bus)
    );

    typedef struct {
        int            cnt;
        bit            full;
        bit            empty;
        bit            afull;
        bit            aempty;
        bit            ovf;
        bit            udf;
        bit            hv;
        logic [DW-1:0] head;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mq[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;
    int            af_th = 24;
    int            ae_th = 4;
    int            n_pass = 0;
    int            n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.cnt    = mq.size();
        e.full   = (mq.size() == DEPTH);
        e.empty  = (mq.size() == 0);
        e.afull  = (mq.size() >= af_th);
        e.aempty = (mq.size() <= ae_th);
        e.ovf    = m_ovf;
        e.udf    = m_udf;
        e.hv     = (mq.size() > 0);
        e.head   = (mq.size() > 0) ? mq[0] : '0;
        return e;
    endfunction

    // Behavioural rules: what the FIFO contents and flags become after one edge.
    function automatic void model_step(bit p, logic [DW-1:0] d, bit q, bit f, bit ec, bit r);
        bit ovs = 1'b0;
        bit uds = 1'b0;
        bit pop, pk;
        int n = mq.size();
        if (!r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            return;
        end
        if (f) begin
            mq.delete();
        end else begin
            pop = q && (n > 0);
            pk  = p && ((n < DEPTH) || pop);
            ovs = p && !pk;
            uds = q && (n == 0);
            if (pop) void'(mq.pop_front());
            if (pk) mq.push_back(d);
        end
        m_ovf = ec ? ovs : (m_ovf | ovs);
        m_udf = ec ? uds : (m_udf | uds);
    endfunction

    task automatic cycle(input bit p, input logic [DW-1:0] d, input bit q,
                         input bit f, input bit ec, input bit r);
        @(negedge clk);
        rstn          = r;
        bus.push      = p;
        bus.wdata     = d;
        bus.pull      = q;
        bus.flush     = f;
        bus.err_clr   = ec;
        bus.afull_th  = (AW+1)'(af_th);
        bus.aempty_th = (AW+1)'(ae_th);
        model_step(p, d, q, f, ec, r);
        exp_q.push_back(snap());
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Reset asserted between edges while a push is being requested.
    task automatic reset_mid();
        @(negedge clk);
        bus.push  = 1'b1;
        bus.wdata = $urandom;
        bus.pull  = 1'b0;
        bus.flush = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("async_cnt", 64'(bus.cnt), 64'd0);
        chk("async_empty", 64'(bus.fifoempty), 64'd1);
        chk("async_full", 64'(bus.full), 64'd0);
        model_step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(snap());
    endtask

    // Monitor: compare the DUT against the oldest prediction after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cnt", 64'(bus.cnt), 64'(e.cnt));
                chk("full", 64'(bus.full), 64'(e.full));
                chk("fifoempty", 64'(bus.fifoempty), 64'(e.empty));
                chk("afull", 64'(bus.afull), 64'(e.afull));
                chk("aempty", 64'(bus.aempty), 64'(e.aempty));
                chk("ovf", 64'(bus.ovf), 64'(e.ovf));
                chk("udf", 64'(bus.udf), 64'(e.udf));
                if (e.hv) chk("rdata", 64'(bus.rdata), 64'(e.head));
            end
        end
    end

    initial begin
        rstn          = 1'b0;
        bus.push      = 1'b0;
        bus.wdata     = '0;
        bus.pull      = 1'b0;
        bus.flush     = 1'b0;
        bus.err_clr   = 1'b0;
        bus.afull_th  = (AW+1)'(af_th);
        bus.aempty_th = (AW+1)'(ae_th);
        #1;
        chk("rst_cnt", 64'(bus.cnt), 64'd0);
        chk("rst_empty", 64'(bus.fifoempty), 64'd1);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        chk("rst_udf", 64'(bus.udf), 64'd0);

        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // Fill with 0..31 then drain; thresholds 24 / 4 exercised on the way.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Push+pull at full, overflow, drain, underflow, then clear.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_00AA, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();

        // Pointer wrap: 20 in, 20 out, 20 in.
        for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Flush with a simultaneous push drops the push.
        for (int i = 0; i < 10; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, $urandom, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 7; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        reset_mid();
        cycle(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();

        // Randomised traffic with varying bias and thresholds (incl. 0 and >= DEPTH).
        for (int seg = 0; seg < 16; seg++) begin
            int push_pct = $urandom_range(15, 85);
            af_th = $urandom_range(0, 40);
            ae_th = $urandom_range(0, 40);
            for (int i = 0; i < 150; i++) begin
                cycle(($urandom_range(0, 99) < push_pct),
                      $urandom,
                      ($urandom_range(0, 99) >= push_pct - 10),
                      ($urandom_range(0, 63) == 0),
                      ($urandom_range(0, 15) == 0),
                      1'b1);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
